// File: rtl/bsg_activation_rr_sched.sv
// Round-robin front end for one shared iterative activation unit.
// Exactly one request is in flight; the answer returns to the requester that issued it.
module bsg_activation_rr_sched #(
    parameter int num_req_p   = 4,
    parameter int ang_width_p = 21,
    parameter int ans_width_p = 32,
    localparam int tag_width_lp = (num_req_p > 1) ? $clog2(num_req_p) : 1
) (
    input  logic                               clk_i,
    input  logic                               reset_n_i,
    input  logic [num_req_p-1:0]               req_v_i,
    input  logic [num_req_p*ang_width_p-1:0]   req_ang_i,
    output logic [num_req_p-1:0]               req_ready_o,
    output logic [num_req_p-1:0]               resp_v_o,
    output logic [ans_width_p-1:0]             resp_ans_o,
    input  logic [num_req_p-1:0]               resp_yumi_i,
    output logic                               unit_v_o,
    output logic [ang_width_p-1:0]             unit_ang_o,
    input  logic                               unit_ready_i,
    input  logic                               unit_v_i,
    input  logic [ans_width_p-1:0]             unit_ans_i,
    output logic                               unit_yumi_o,
    output logic                               busy_o
);

    typedef enum logic [1:0] {eIDLE, eISSUE, eBUSY, eRETURN} state_e;

    state_e                                  state_r, state_n;
    logic [tag_width_lp-1:0]                 last_r, tag_r, grant_tag;
    logic                                    grant_v;
    logic [ang_width_p-1:0]                  ang_r;
    logic [ans_width_p-1:0]                  ans_r;
    logic [num_req_p-1:0][ang_width_p-1:0]   ang_vec;

    assign ang_vec = req_ang_i;

    // Walk offsets from farthest to nearest so the requester just after last_r wins.
    always_comb begin
        grant_v   = 1'b0;
        grant_tag = '0;
        for (int i = num_req_p; i >= 1; i--) begin
            if (req_v_i[(int'(last_r) + i) % num_req_p]) begin
                grant_v   = 1'b1;
                grant_tag = tag_width_lp'((int'(last_r) + i) % num_req_p);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) state_r <= eIDLE;
        else            state_r <= state_n;
    end

    always_comb begin
        state_n     = state_r;
        unit_v_o    = 1'b0;
        unit_yumi_o = 1'b0;
        case (state_r)
            eIDLE:   if (grant_v) state_n = eISSUE;
            eISSUE: begin
                unit_v_o = 1'b1;
                if (unit_ready_i) state_n = eBUSY;
            end
            eBUSY: begin
                if (unit_v_i) begin
                    unit_yumi_o = 1'b1;
                    state_n     = eRETURN;
                end
            end
            eRETURN: if (resp_yumi_i[tag_r]) state_n = eIDLE;
            default: state_n = eIDLE;
        endcase
    end

    // Priority pointer moves on response completion only, never on accept.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            last_r <= tag_width_lp'(num_req_p - 1);
            tag_r  <= '0;
            ang_r  <= '0;
            ans_r  <= '0;
        end else begin
            if (state_r == eIDLE && grant_v) begin
                tag_r <= grant_tag;
                ang_r <= ang_vec[grant_tag];
            end
            if (state_r == eBUSY && unit_v_i)
                ans_r <= unit_ans_i;
            if (state_r == eRETURN && resp_yumi_i[tag_r])
                last_r <= tag_r;
        end
    end

    for (genvar g = 0; g < num_req_p; g++) begin : g_lane
        assign req_ready_o[g] = (state_r == eIDLE) & grant_v & (grant_tag == tag_width_lp'(g));
        assign resp_v_o[g]    = (state_r == eRETURN) & (tag_r == tag_width_lp'(g));
    end

    assign resp_ans_o = ans_r;
    assign unit_ang_o = ang_r;
    assign busy_o     = (state_r != eIDLE);

    // A unit result outside eBUSY has no owner and would be dropped silently.
    unit_v_outside_busy: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        !(unit_v_i && state_r != eBUSY));

endmodule

// File: tb/tb_bsg_activation_rr_sched.sv
// Directed bench for bsg_activation_rr_sched: latency, fairness, back-pressure,
// wrong-owner consume and mid-operation reset, with hand-computed expectations.
module tb_bsg_activation_rr_sched;

    logic              clk_i = 1'b0;
    logic              reset_n_i;
    logic [3:0]        req_v;
    logic [3:0][20:0]  req_ang;
    logic [3:0]        req_ready;
    logic [3:0]        resp_v;
    logic [31:0]       resp_ans;
    logic [3:0]        resp_yumi;
    logic              unit_v_o;
    logic [20:0]       unit_ang;
    logic              unit_ready;
    logic              unit_v_i;
    logic [31:0]       unit_ans;
    logic              unit_yumi;
    logic              busy;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    bsg_activation_rr_sched #(.num_req_p(4), .ang_width_p(21), .ans_width_p(32)) dut (
        .clk_i       (clk_i),
        .reset_n_i   (reset_n_i),
        .req_v_i     (req_v),
        .req_ang_i   (req_ang),
        .req_ready_o (req_ready),
        .resp_v_o    (resp_v),
        .resp_ans_o  (resp_ans),
        .resp_yumi_i (resp_yumi),
        .unit_v_o    (unit_v_o),
        .unit_ang_o  (unit_ang),
        .unit_ready_i(unit_ready),
        .unit_v_i    (unit_v_i),
        .unit_ans_i  (unit_ans),
        .unit_yumi_o (unit_yumi),
        .busy_o      (busy)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change 1ns after the edge; outputs are sampled 1ns later still.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        reset_n_i = 1'b0;
        req_v = '0; resp_yumi = '0; unit_ready = 1'b0; unit_v_i = 1'b0; unit_ans = '0;
        tick(); tick();
        reset_n_i = 1'b1;
    endtask

    initial begin
        req_ang = '0;
        do_reset();
        settle();
        chk("rst_ready",  req_ready, 4'b0000);
        chk("rst_resp_v", resp_v,    4'b0000);
        chk("rst_unit_v", unit_v_o,  1'b0);
        chk("rst_yumi",   unit_yumi, 1'b0);
        chk("rst_busy",   busy,      1'b0);
        chk("rst_ans",    resp_ans,  32'h0);

        // Single request: accept at 0, issue at 1, result at 20, response at 21.
        req_v = 4'b0100; req_ang[2] = 21'h01000; unit_ready = 1'b1;
        settle();
        chk("c0_ready", req_ready, 4'b0100);
        tick();
        req_v = '0;
        settle();
        chk("c1_unit_v",   unit_v_o, 1'b1);
        chk("c1_unit_ang", unit_ang, 21'h01000);
        chk("c1_busy",     busy,     1'b1);
        tick();
        for (int c = 2; c < 20; c++) begin
            settle();
            if (c == 10) chk("wait_no_yumi", unit_yumi, 1'b0);
            tick();
        end
        unit_v_i = 1'b1; unit_ans = 32'h0000C4E6;
        settle();
        chk("c20_yumi", unit_yumi, 1'b1);
        tick();
        unit_v_i = 1'b0;
        settle();
        chk("c21_resp_v",   resp_v,   4'b0100);
        chk("c21_resp_ans", resp_ans, 32'h0000C4E6);
        resp_yumi = 4'b0100;
        tick();
        resp_yumi = '0;
        settle();
        chk("c22_busy",   busy,   1'b0);
        chk("c22_resp_v", resp_v, 4'b0000);

        // Fairness: four requesters held high get served 0,1,2,3,0,1,2,3.
        do_reset();
        for (int i = 0; i < 4; i++) req_ang[i] = 21'h00100 + 21'(i);
        req_v = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            settle();
            chk($sformatf("fair%0d_grant", k), req_ready, 4'b0001 << (k % 4));
            tick();
            unit_ready = 1'b1;
            settle();
            chk($sformatf("fair%0d_ang", k), unit_ang, 21'h00100 + 21'(k % 4));
            chk($sformatf("fair%0d_noready", k), req_ready, 4'b0000);
            tick();
            unit_v_i = 1'b1; unit_ans = 32'hA000 + 32'(k);
            tick();
            unit_v_i = 1'b0;
            settle();
            chk($sformatf("fair%0d_resp_v", k), resp_v, 4'b0001 << (k % 4));
            chk($sformatf("fair%0d_ans", k), resp_ans, 32'hA000 + 32'(k));
            resp_yumi = 4'b0001 << (k % 4);
            tick();
            resp_yumi = '0;
        end

        // Back-pressure on both the unit side and the response side.
        do_reset();
        req_v = 4'b0010; req_ang[1] = 21'h1ABCD;
        settle();
        chk("bp_grant", req_ready, 4'b0010);
        tick();
        req_v = 4'b1111; unit_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            settle();
            chk($sformatf("bp_unit_v%0d", c), unit_v_o, 1'b1);
            chk($sformatf("bp_ang%0d", c), unit_ang, 21'h1ABCD);
            chk($sformatf("bp_noready%0d", c), req_ready, 4'b0000);
            tick();
        end
        unit_ready = 1'b1;
        tick();
        unit_v_i = 1'b1; unit_ans = 32'hDEADBEEF;
        tick();
        unit_v_i = 1'b0;
        for (int c = 0; c < 7; c++) begin
            settle();
            chk($sformatf("bp_resp_v%0d", c), resp_v, 4'b0010);
            chk($sformatf("bp_resp_ans%0d", c), resp_ans, 32'hDEADBEEF);
            chk($sformatf("bp_rnoready%0d", c), req_ready, 4'b0000);
            tick();
        end
        resp_yumi = 4'b0010;
        tick();
        resp_yumi = '0;
        settle();
        chk("bp_next_grant", req_ready, 4'b0100);

        // Wrong-owner consume: tag 2 is in flight, other yumi bits are ignored.
        tick();
        req_v = '0;
        tick();
        unit_v_i = 1'b1; unit_ans = 32'h00005555;
        tick();
        unit_v_i = 1'b0;
        resp_yumi = 4'b0001;
        tick();
        settle();
        chk("wo_hold_resp_v", resp_v, 4'b0100);
        chk("wo_hold_busy",   busy,   1'b1);
        resp_yumi = 4'b1011;
        tick();
        chk("wo_hold2_resp_v", resp_v, 4'b0100);
        resp_yumi = 4'b0100;
        tick();
        resp_yumi = '0;
        settle();
        chk("wo_idle_busy", busy, 1'b0);
        req_v = 4'b1111;
        settle();
        chk("wo_last2_grant", req_ready, 4'b1000);
        req_v = 4'b0011;
        settle();
        chk("wo_wrap_grant", req_ready, 4'b0001);

        // Reset while in eBUSY drops the request; requester 0 regains priority.
        req_v = 4'b1000; req_ang[3] = 21'h0F0F0;
        tick();
        req_v = '0;
        tick();
        settle();
        chk("mr_busy_before", busy, 1'b1);
        reset_n_i = 1'b0;
        tick();
        settle();
        chk("mr_ready",   req_ready, 4'b0000);
        chk("mr_resp_v",  resp_v,    4'b0000);
        chk("mr_unit_v",  unit_v_o,  1'b0);
        chk("mr_yumi",    unit_yumi, 1'b0);
        chk("mr_busy",    busy,      1'b0);
        chk("mr_ans",     resp_ans,  32'h0);
        chk("mr_ang",     unit_ang,  21'h0);
        reset_n_i = 1'b1;
        req_v = 4'b1111;
        settle();
        chk("mr_first_grant", req_ready, 4'b0001);
        tick();
        req_v = '0;
        settle();
        chk("mr_first_ang", unit_ang, 21'h00100);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
